neosd_resp_rx: RTL and testbench

Receiver for SD command-line responses; the return path of the neosd command transmitter. After a command's end bit, the controller arms this block. It watches `sd_cmd_i` for the response start bit and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame. It checks the transmission bit, CRC7 and end bit, and presents the payload for the RESP0..3 registers along with a one-cycle completion pulse.

---
 rtl/neosd_resp_rx.sv | 202 ++++++++++++++++++++
 tb/tb_neosd_resp_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neosd_resp_rx.sv
// SD command-line response receiver: waits for the start bit, shifts in a 48- or 136-bit
// frame, checks transmission bit, CRC7 and end bit, and presents the payload fields.
module neosd_resp_rx #(
    parameter int unsigned TIMEOUT_SAMPLES = 64
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         sample_en_i,
    input  logic         start_i,
    input  logic         long_i,
    input  logic         crc_chk_i,
    input  logic         abort_i,
    input  logic         sd_cmd_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [5:0]   resp_idx_o,
    output logic [127:0] resp_data_o,
    output logic [6:0]   resp_crc_o,
    output logic         err_timeout_o,
    output logic         err_crc_o,
    output logic         err_end_o,
    output logic         err_tx_o
);

    localparam int unsigned   TW       = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_RECV,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           long_q, long_d;
    logic           chk_q, chk_d;
    logic [7:0]     bitcnt_q, bitcnt_d;
    logic [TW-1:0]  tocnt_q, tocnt_d;
    logic [6:0]     crc_q, crc_d;
    logic [133:0]   sr_q, sr_d;
    logic [5:0]     idx_q, idx_d;
    logic [127:0]   data_q, data_d;
    logic [6:0]     rcrc_q, rcrc_d;
    logic           e_to_q, e_to_d;
    logic           e_crc_q, e_crc_d;
    logic           e_end_q, e_end_d;
    logic           e_tx_q, e_tx_d;

    logic [7:0]     last_pos;
    logic           crc_in_range;
    logic [6:0]     crc_next;
    logic [TW-1:0]  tocnt_inc;

    // bitcnt_q holds the position (0 = start bit) of the bit arriving on this sample.
    // Frame bit k (k >= 1) of the completed frame sits in sr_q[k-1] on the last sample.
    always_comb begin
        last_pos     = long_q ? 8'd135 : 8'd47;
        crc_in_range = long_q ? ((bitcnt_q >= 8'd8) && (bitcnt_q < 8'd128))
                              : (bitcnt_q < 8'd40);
        crc_next     = {crc_q[5:0], 1'b0} ^ ((crc_q[6] ^ sd_cmd_i) ? 7'h09 : 7'h00);
        tocnt_inc    = (tocnt_q == TO_LIMIT) ? tocnt_q : tocnt_q + TW'(1);
    end

    always_comb begin
        state_d  = state_q;
        long_d   = long_q;
        chk_d    = chk_q;
        bitcnt_d = bitcnt_q;
        tocnt_d  = tocnt_q;
        crc_d    = crc_q;
        sr_d     = sr_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rcrc_d   = rcrc_q;
        e_to_d   = e_to_q;
        e_crc_d  = e_crc_q;
        e_end_d  = e_end_q;
        e_tx_d   = e_tx_q;

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    bitcnt_d = '0;
                    tocnt_d  = '0;
                    crc_d    = '0;
                    if (start_i) begin
                        state_d = S_WAIT_START;
                        long_d  = long_i;
                        chk_d   = crc_chk_i;
                        sr_d    = '0;
                        idx_d   = '0;
                        data_d  = '0;
                        rcrc_d  = '0;
                        e_to_d  = 1'b0;
                        e_crc_d = 1'b0;
                        e_end_d = 1'b0;
                        e_tx_d  = 1'b0;
                    end
                end
                S_WAIT_START: begin
                    if (sample_en_i) begin
                        if (!sd_cmd_i) begin
                            state_d  = S_RECV;
                            bitcnt_d = 8'd1;
                            sr_d     = {sr_q[132:0], 1'b0};
                            // Long-frame CRC starts at the payload, so the start bit is excluded.
                            if (!long_q) begin
                                crc_d = crc_next;
                            end
                        end else begin
                            tocnt_d = tocnt_inc;
                            if (tocnt_inc == TO_LIMIT) begin
                                state_d = S_DONE;
                                e_to_d  = 1'b1;
                            end
                        end
                    end
                end
                S_RECV: begin
                    if (sample_en_i) begin
                        sr_d     = {sr_q[132:0], sd_cmd_i};
                        bitcnt_d = bitcnt_q + 8'd1;
                        if (crc_in_range) begin
                            crc_d = crc_next;
                        end
                        if (bitcnt_q == last_pos) begin
                            state_d = S_DONE;
                            rcrc_d  = sr_q[6:0];
                            e_end_d = !sd_cmd_i;
                            e_crc_d = chk_q && (crc_q != sr_q[6:0]);
                            if (long_q) begin
                                idx_d  = sr_q[132:127];
                                data_d = {sr_q[126:0], 1'b0};
                                e_tx_d = sr_q[133];
                            end else begin
                                idx_d  = sr_q[44:39];
                                data_d = {96'b0, sr_q[38:7]};
                                e_tx_d = sr_q[45];
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            long_q   <= 1'b0;
            chk_q    <= 1'b0;
            bitcnt_q <= '0;
            tocnt_q  <= '0;
            crc_q    <= '0;
            sr_q     <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            rcrc_q   <= '0;
            e_to_q   <= 1'b0;
            e_crc_q  <= 1'b0;
            e_end_q  <= 1'b0;
            e_tx_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            long_q   <= long_d;
            chk_q    <= chk_d;
            bitcnt_q <= bitcnt_d;
            tocnt_q  <= tocnt_d;
            crc_q    <= crc_d;
            sr_q     <= sr_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            rcrc_q   <= rcrc_d;
            e_to_q   <= e_to_d;
            e_crc_q  <= e_crc_d;
            e_end_q  <= e_end_d;
            e_tx_q   <= e_tx_d;
        end
    end

    always_comb begin
        busy_o        = (state_q == S_WAIT_START) || (state_q == S_RECV);
        done_o        = (state_q == S_DONE);
        resp_idx_o    = idx_q;
        resp_data_o   = data_q;
        resp_crc_o    = rcrc_q;
        err_timeout_o = e_to_q;
        err_crc_o     = e_crc_q;
        err_end_o     = e_end_q;
        err_tx_o      = e_tx_q;
    end

endmodule

// File: tb/tb_neosd_resp_rx.sv
// Scoreboard bench for neosd_resp_rx: frames are built and their expected decode derived
// from field layout and CRC7 polynomial division; a monitor checks each done_o pulse.
module tb_neosd_resp_rx;

    localparam int unsigned TO = 64;

    logic         clk = 1'b0;
    logic         rstn_i, sample_en_i, start_i, long_i, crc_chk_i, abort_i, sd_cmd_i;
    logic         busy_o, done_o;
    logic [5:0]   resp_idx_o;
    logic [127:0] resp_data_o;
    logic [6:0]   resp_crc_o;
    logic         err_timeout_o, err_crc_o, err_end_o, err_tx_o;

    always #5 clk = ~clk;

    neosd_resp_rx #(.TIMEOUT_SAMPLES(TO)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .sample_en_i(sample_en_i), .start_i(start_i),
        .long_i(long_i), .crc_chk_i(crc_chk_i), .abort_i(abort_i), .sd_cmd_i(sd_cmd_i),
        .busy_o(busy_o), .done_o(done_o), .resp_idx_o(resp_idx_o), .resp_data_o(resp_data_o),
        .resp_crc_o(resp_crc_o), .err_timeout_o(err_timeout_o), .err_crc_o(err_crc_o),
        .err_end_o(err_end_o), .err_tx_o(err_tx_o)
    );

    typedef struct {
        logic [5:0]   idx;
        logic [127:0] data;
        logic [6:0]   crc;
        logic         e_to, e_crc, e_end, e_tx;
        logic         chk_data;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int n);
        logic [134:0] r;
        r = 135'(msg) << 7;
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {88'b0, m, crc7_ref({88'b0, m}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] mk_long(input logic [119:0] cid);
        return {2'b00, 6'h3F, cid, crc7_ref({8'b0, cid}, 120), 1'b1};
    endfunction

    function automatic exp_t model(input logic [135:0] f, input logic lng, input logic chk);
        exp_t e;
        e.chk_data = 1'b1;
        e.e_to     = 1'b0;
        e.cyc      = 0;
        e.crc      = f[7:1];
        e.e_end    = ~f[0];
        if (lng) begin
            e.idx   = f[133:128];
            e.data  = {f[127:1], 1'b0};
            e.e_tx  = f[134];
            e.e_crc = chk && (crc7_ref({8'b0, f[127:8]}, 120) != f[7:1]);
        end else begin
            e.idx   = f[45:40];
            e.data  = {96'b0, f[39:8]};
            e.e_tx  = f[46];
            e.e_crc = chk && (crc7_ref({88'b0, f[47:8]}, 40) != f[7:1]);
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done_o) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion pending");
            end else begin
                e = sb.pop_front();
                check("done_cycle", 128'(cyc), 128'(e.cyc));
                check("busy_at_done", busy_o, 1'b0);
                check("err_timeout", err_timeout_o, e.e_to);
                check("err_crc", err_crc_o, e.e_crc);
                check("err_end", err_end_o, e.e_end);
                check("err_tx", err_tx_o, e.e_tx);
                if (e.chk_data) begin
                    check("resp_idx", resp_idx_o, e.idx);
                    check("resp_data", resp_data_o, e.data);
                    check("resp_crc", resp_crc_o, e.crc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic b, input int gap);
        sd_cmd_i    = b;
        sample_en_i = 1'b1;
        tick();
        sample_en_i = 1'b0;
        repeat (gap) begin
            sd_cmd_i = 1'($urandom);
            tick();
        end
    endtask

    task automatic arm(input logic lng, input logic chk);
        start_i   = 1'b1;
        long_i    = lng;
        crc_chk_i = chk;
        tick();
        start_i   = 1'b0;
        long_i    = 1'($urandom);
        crc_chk_i = 1'($urandom);
        check("busy_after_start", busy_o, 1'b1);
    endtask

    // Sends highs, then bits n-1..first_stop (first_stop=0 sends the whole frame).
    task automatic send_frame(input logic [135:0] f, input int n, input int highs, input int gap,
                              input int first_stop, input exp_t e);
        exp_t ee;
        ee = e;
        for (int i = 0; i < highs; i++) sample(1'b1, gap);
        for (int i = n - 1; i >= first_stop; i--) begin
            if (i == 0) begin
                ee.cyc = cyc + 1;
                sb.push_back(ee);
            end
            // A start request mid-frame must be ignored.
            if (i == n / 2) begin
                start_i = 1'b1;
                long_i  = 1'($urandom);
            end
            sample(f[i], gap);
            start_i = 1'b0;
        end
        sd_cmd_i = 1'b1;
    endtask

    task automatic run(input logic [135:0] f, input logic lng, input logic chk, input int highs,
                       input int gap, input exp_t e);
        arm(lng, chk);
        send_frame(f, lng ? 136 : 48, highs, gap, 0, e);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_idx"}, resp_idx_o, 6'd0);
        check({tag, "_data"}, resp_data_o, 128'd0);
        check({tag, "_crc"}, resp_crc_o, 7'd0);
        check({tag, "_errs"}, {err_timeout_o, err_crc_o, err_end_o, err_tx_o}, 4'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [135:0] f, base;
        logic [119:0] cid;
        exp_t         e;
        logic         lng, chk;

        rstn_i = 1'b0; sample_en_i = 1'b0; start_i = 1'b0; long_i = 1'b0;
        crc_chk_i = 1'b0; abort_i = 1'b0; sd_cmd_i = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rstn_i = 1'b1;
        tick();

        // Directed valid short response with spec-given fields.
        base = 136'h110000090067;
        e = '{idx: 6'd17, data: 128'h900, crc: 7'h33, e_to: 0, e_crc: 0, e_end: 0, e_tx: 0,
              chk_data: 1, cyc: 0};
        run(base, 1'b0, 1'b1, 3, 0, e);

        // Corruptions: argument bit, end bit, transmission bit.
        f = base; f[20] = ~f[20];
        e = model(f, 1'b0, 1'b1);
        check("model_argflip_crcerr", e.e_crc, 1'b1);
        run(f, 1'b0, 1'b1, 2, 1, e);
        f = base; f[0] = 1'b0;
        run(f, 1'b0, 1'b1, 0, 0, model(f, 1'b0, 1'b1));
        f = base; f[46] = 1'b1;
        run(f, 1'b0, 1'b1, 1, 0, model(f, 1'b0, 1'b1));

        // Timeout after TO high samples.
        arm(1'b0, 1'b1);
        e = '{idx: 0, data: 0, crc: 0, e_to: 1, e_crc: 0, e_end: 0, e_tx: 0, chk_data: 0, cyc: 0};
        for (int i = 0; i < int'(TO); i++) begin
            if (i == int'(TO) - 1) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
            sample(1'b1, 0);
        end
        tick();
        // TO-1 highs then a start bit is still a valid response.
        run(base, 1'b0, 1'b1, TO - 1, 0, model(base, 1'b0, 1'b1));

        // R3 with CRC check disabled.
        f = {88'b0, 2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
        e = '{idx: 6'h3F, data: 128'h80FF8000, crc: 7'h7F, e_to: 0, e_crc: 0, e_end: 0, e_tx: 0,
              chk_data: 1, cyc: 0};
        run(f, 1'b0, 1'b0, 4, 0, e);

        // R2 long response, back-to-back samples and every 4th cycle.
        cid = 120'h035344534430313680a1b2c3d4e5f6;
        e = '{idx: 6'h3F, data: {cid, crc7_ref({8'b0, cid}, 120), 1'b0}, crc: crc7_ref({8'b0, cid}, 120),
              e_to: 0, e_crc: 0, e_end: 0, e_tx: 0, chk_data: 1, cyc: 0};
        run(mk_long(cid), 1'b1, 1'b1, 2, 0, e);
        run(mk_long(cid), 1'b1, 1'b1, 2, 3, e);

        // start_i during DONE is ignored and taken one cycle later.
        arm(1'b0, 1'b1);
        send_frame(base, 48, 0, 0, 0, model(base, 1'b0, 1'b1));
        start_i = 1'b1; long_i = 1'b0; crc_chk_i = 1'b1;
        tick();
        check("start_in_done_ignored", busy_o, 1'b0);
        tick();
        start_i = 1'b0;
        check("start_after_done", busy_o, 1'b1);
        send_frame(base, 48, 1, 0, 0, model(base, 1'b0, 1'b1));
        tick();

        // start and abort together: abort wins.
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        check("start_abort_idle", busy_o, 1'b0);

        // Abort at bit 20 then immediate re-arm.
        f = mk_short(6'h2A, 32'hDEADBEEF);
        arm(1'b0, 1'b1);
        send_frame(f, 48, 2, 0, 28, e);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        run(f, 1'b0, 1'b1, 0, 0, model(f, 1'b0, 1'b1));

        // Reset mid long frame.
        arm(1'b1, 1'b1);
        send_frame(mk_long(cid), 136, 1, 0, 86, e);
        rstn_i = 1'b0;
        tick();
        check_all_zero("midreset");
        rstn_i = 1'b1;
        tick();

        // Randomized frames with occasional single-bit corruption.
        for (int k = 0; k < 40; k++) begin
            lng = 1'($urandom);
            chk = 1'($urandom);
            if (lng) f = mk_long(120'({$urandom, $urandom, $urandom, $urandom}));
            else     f = mk_short(6'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                int b;
                b = int'($urandom_range(0, lng ? 134 : 46));
                f[b] = ~f[b];
            end
            run(f, lng, chk, int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                model(f, lng, chk));
        end

        repeat (4) tick();
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
